// File: rtl/icache_set_assoc.sv
// Set-associative instruction cache with multi-word lines, burst refill,
// per-set round-robin replacement and a core-driven invalidate-all sweep.
// The tag compare runs in the cycle a read is accepted, so hit_o and
// instr_o come straight from registers in the following cycle.
module icache_set_assoc #(
    parameter int DWidth    = 32,
    parameter int Sets      = 64,
    parameter int Ways      = 2,
    parameter int LineWords = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              read_i,
    input  logic [DWidth-1:0] addr_i,
    input  logic              flush_i,
    input  logic [DWidth-1:0] imem_rdata_i,
    input  logic              imem_ready_i,
    output logic [DWidth-1:0] imem_addr_o,
    output logic              imem_req_o,
    output logic [DWidth-1:0] instr_o,
    output logic              hit_o,
    output logic              busy_o
);

    localparam int OffW   = $clog2(LineWords);
    localparam int OffWS  = (OffW > 0) ? OffW : 1;
    localparam int IdxW   = $clog2(Sets);
    localparam int WayW   = (Ways > 1) ? $clog2(Ways) : 1;
    localparam int TagW   = DWidth - 2 - OffW - IdxW;
    localparam int WordSh = 2;
    localparam int IdxSh  = 2 + OffW;
    localparam int TagSh  = 2 + OffW + IdxW;

    localparam logic [DWidth-1:0] LineMask  = ~DWidth'(LineWords * 4 - 1);
    localparam logic [DWidth-1:0] OffMask   = DWidth'(LineWords - 1);
    localparam logic [DWidth-1:0] WordBytes = DWidth'(4);
    localparam logic [OffWS-1:0]  LastBeat  = OffWS'(LineWords - 1);
    localparam logic [OffWS-1:0]  OneBeat   = OffWS'(1);
    localparam logic [IdxW-1:0]   LastSet   = IdxW'(Sets - 1);
    localparam logic [IdxW-1:0]   OneSet    = IdxW'(1);
    localparam logic [WayW-1:0]   LastWay   = WayW'(Ways - 1);
    localparam logic [WayW-1:0]   OneWayCnt = WayW'(1);
    localparam logic [Ways-1:0]   OneWay    = Ways'(1);

    typedef enum logic [2:0] {
        ST_SWEEP   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_LOOKUP  = 3'd2,
        ST_REFILL  = 3'd3,
        ST_RESPOND = 3'd4
    } state_e;

    function automatic logic [OffWS-1:0] addr_off(input logic [DWidth-1:0] a);
        logic [DWidth-1:0] t;
        t = (a >> WordSh) & OffMask;
        return t[OffWS-1:0];
    endfunction

    function automatic logic [IdxW-1:0] addr_idx(input logic [DWidth-1:0] a);
        logic [DWidth-1:0] t;
        t = a >> IdxSh;
        return t[IdxW-1:0];
    endfunction

    function automatic logic [TagW-1:0] addr_tag(input logic [DWidth-1:0] a);
        logic [DWidth-1:0] t;
        t = a >> TagSh;
        return t[TagW-1:0];
    endfunction

    // Control registers and their next-state values
    state_e            state_q, state_d;
    logic [IdxW-1:0]   sweep_cnt_q, sweep_cnt_d;
    logic [OffWS-1:0]  beat_q, beat_d;
    logic [DWidth-1:0] req_addr_q, req_addr_d;
    logic [WayW-1:0]   victim_q, victim_d;
    logic              pend_q, pend_d;
    logic              hit_q, hit_d;
    logic [DWidth-1:0] instr_q, instr_d;
    logic [DWidth-1:0] crit_q, crit_d;
    logic              imem_req_q, imem_req_d;
    logic [DWidth-1:0] imem_addr_q, imem_addr_d;
    logic              busy_q, busy_d;

    // Cache storage
    logic [Ways-1:0]   valid_q [Sets];
    logic [TagW-1:0]   tag_q   [Ways][Sets];
    logic [DWidth-1:0] data_q  [Ways][Sets][LineWords];

    // Lookup on the incoming address
    logic [IdxW-1:0]   lk_idx_s;
    logic [TagW-1:0]   lk_tag_s;
    logic [OffWS-1:0]  lk_off_s;
    logic [Ways-1:0]   match_s;
    logic              lk_hit_s;
    logic [DWidth-1:0] lk_word_s;

    // Fields of the request being serviced
    logic [IdxW-1:0]   rq_idx_s;
    logic [TagW-1:0]   rq_tag_s;
    logic [OffWS-1:0]  rq_off_s;

    // Replacement and storage-write strobes
    logic              inv_found_s;
    logic [WayW-1:0]   inv_way_s;
    logic [WayW-1:0]   ptr_rd_s;
    logic [WayW-1:0]   victim_s;
    logic              flush_any_s;
    logic              accept_s;
    logic              valid_clr_s;
    logic              ptr_clr_s;
    logic              ptr_inc_s;
    logic              data_we_s;
    logic              line_commit_s;

    assign rq_idx_s = addr_idx(req_addr_q);
    assign rq_tag_s = addr_tag(req_addr_q);
    assign rq_off_s = addr_off(req_addr_q);

    // Compare the fetch address against every way; a hit needs exactly one match
    always_comb begin
        lk_idx_s  = addr_idx(addr_i);
        lk_tag_s  = addr_tag(addr_i);
        lk_off_s  = addr_off(addr_i);
        match_s   = '0;
        lk_word_s = '0;
        for (int w = 0; w < Ways; w++) begin
            match_s[w] = valid_q[lk_idx_s][w] && (tag_q[w][lk_idx_s] == lk_tag_s);
            if (match_s[w]) begin
                lk_word_s = data_q[w][lk_idx_s][lk_off_s];
            end else begin
                lk_word_s = lk_word_s;
            end
        end
        lk_hit_s = (match_s != '0) && ((match_s & (match_s - OneWay)) == '0);
    end

    // Victim: lowest invalid way of the request's set, else that set's pointer
    always_comb begin
        inv_found_s = 1'b0;
        inv_way_s   = '0;
        for (int w = Ways - 1; w >= 0; w--) begin
            if (!valid_q[rq_idx_s][w]) begin
                inv_found_s = 1'b1;
                inv_way_s   = WayW'(w);
            end else begin
                inv_found_s = inv_found_s;
            end
        end
        victim_s = inv_found_s ? inv_way_s : ptr_rd_s;
    end

    generate
        if (Ways > 1) begin : g_ptr
            logic [WayW-1:0] ptr_q [Sets];

            assign ptr_rd_s = ptr_q[rq_idx_s];

            // Round-robin pointers: cleared by the sweep, advanced when a valid way is evicted
            always_ff @(posedge clk_i) begin
                if (ptr_clr_s) begin
                    ptr_q[sweep_cnt_q] <= '0;
                end else if (ptr_inc_s) begin
                    ptr_q[rq_idx_s] <= (ptr_rd_s == LastWay) ? '0 : ptr_rd_s + OneWayCnt;
                end
            end
        end else begin : g_noptr
            assign ptr_rd_s = '0;
        end
    endgenerate

    // Next-state logic for the sweep / lookup / refill sequencer
    always_comb begin
        state_d       = state_q;
        sweep_cnt_d   = sweep_cnt_q;
        beat_d        = beat_q;
        req_addr_d    = req_addr_q;
        victim_d      = victim_q;
        pend_d        = pend_q;
        hit_d         = 1'b0;
        instr_d       = instr_q;
        crit_d        = crit_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        busy_d        = busy_q;
        accept_s      = 1'b0;
        valid_clr_s   = 1'b0;
        ptr_clr_s     = 1'b0;
        ptr_inc_s     = 1'b0;
        data_we_s     = 1'b0;
        line_commit_s = 1'b0;
        flush_any_s   = pend_q | flush_i;

        case (state_q)
            ST_SWEEP: begin
                valid_clr_s = 1'b1;
                ptr_clr_s   = 1'b1;
                if (sweep_cnt_q == LastSet) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    sweep_cnt_d = '0;
                end else begin
                    sweep_cnt_d = sweep_cnt_q + OneSet;
                end
            end
            ST_IDLE: begin
                if (flush_i) begin
                    state_d     = ST_SWEEP;
                    sweep_cnt_d = '0;
                    busy_d      = 1'b1;
                    pend_d      = 1'b0;
                end else if (read_i) begin
                    accept_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (!hit_q) begin
                    state_d     = ST_REFILL;
                    victim_d    = victim_s;
                    ptr_inc_s   = !inv_found_s;
                    beat_d      = '0;
                    imem_req_d  = 1'b1;
                    imem_addr_d = req_addr_q & LineMask;
                    pend_d      = flush_any_s;
                end else if (flush_any_s) begin
                    state_d     = ST_SWEEP;
                    sweep_cnt_d = '0;
                    busy_d      = 1'b1;
                    pend_d      = 1'b0;
                end else if (read_i) begin
                    accept_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REFILL: begin
                pend_d = flush_any_s;
                if (imem_ready_i) begin
                    data_we_s = 1'b1;
                    if (beat_q == rq_off_s) begin
                        crit_d = imem_rdata_i;
                    end else begin
                        crit_d = crit_q;
                    end
                    if (beat_q == LastBeat) begin
                        line_commit_s = 1'b1;
                        imem_req_d    = 1'b0;
                        state_d       = ST_RESPOND;
                        hit_d         = 1'b1;
                        instr_d       = (beat_q == rq_off_s) ? imem_rdata_i : crit_q;
                    end else begin
                        beat_d      = beat_q + OneBeat;
                        imem_addr_d = imem_addr_q + WordBytes;
                    end
                end else begin
                    state_d = ST_REFILL;
                end
            end
            ST_RESPOND: begin
                if (flush_any_s) begin
                    state_d     = ST_SWEEP;
                    sweep_cnt_d = '0;
                    busy_d      = 1'b1;
                    pend_d      = 1'b0;
                end else if (read_i) begin
                    accept_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_SWEEP;
                sweep_cnt_d = '0;
                busy_d      = 1'b1;
                pend_d      = 1'b0;
                imem_req_d  = 1'b0;
            end
        endcase

        if (accept_s) begin
            state_d    = ST_LOOKUP;
            req_addr_d = addr_i;
            hit_d      = lk_hit_s;
            instr_d    = lk_hit_s ? lk_word_s : instr_q;
        end else begin
            req_addr_d = req_addr_d;
        end

        // A reset cycle must never leave a partial line or a moved pointer behind
        data_we_s     = data_we_s && !rst_i;
        line_commit_s = line_commit_s && !rst_i;
        ptr_inc_s     = ptr_inc_s && !rst_i;
    end

    // Sequencer and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_SWEEP;
            sweep_cnt_q <= '0;
            beat_q      <= '0;
            req_addr_q  <= '0;
            victim_q    <= '0;
            pend_q      <= 1'b0;
            hit_q       <= 1'b0;
            instr_q     <= '0;
            crit_q      <= '0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            beat_q      <= beat_d;
            req_addr_q  <= req_addr_d;
            victim_q    <= victim_d;
            pend_q      <= pend_d;
            hit_q       <= hit_d;
            instr_q     <= instr_d;
            crit_q      <= crit_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            busy_q      <= busy_d;
        end
    end

    // Valid/tag/data storage: sweep clears valid bits, refill writes words then commits the line
    always_ff @(posedge clk_i) begin
        if (valid_clr_s) begin
            valid_q[sweep_cnt_q] <= '0;
        end else if (line_commit_s) begin
            valid_q[rq_idx_s][victim_q] <= 1'b1;
            tag_q[victim_q][rq_idx_s]   <= rq_tag_s;
        end
        if (data_we_s) begin
            data_q[victim_q][rq_idx_s][beat_q] <= imem_rdata_i;
        end
    end

    assign imem_addr_o = imem_addr_q;
    assign imem_req_o  = imem_req_q;
    assign instr_o     = instr_q;
    assign hit_o       = hit_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_icache_set_assoc.sv
// Bench for icache_set_assoc: directed vector table, hand-written multi-cycle
// sequences, and a randomized phase checked against a set/way residency model.
module tb_icache_set_assoc;

    localparam int SETS = 64;
    localparam int WAYS = 2;
    localparam int LW   = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        read_i = 1'b0;
    logic [31:0] addr_i = 32'h0;
    logic        flush_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic        imem_ready_i = 1'b0;
    logic [31:0] imem_addr_o;
    logic        imem_req_o;
    logic [31:0] instr_o;
    logic        hit_o;
    logic        busy_o;

    always #5 clk = ~clk;

    icache_set_assoc #(.DWidth(32), .Sets(SETS), .Ways(WAYS), .LineWords(LW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .read_i       (read_i),
        .addr_i       (addr_i),
        .flush_i      (flush_i),
        .imem_rdata_i (imem_rdata_i),
        .imem_ready_i (imem_ready_i),
        .imem_addr_o  (imem_addr_o),
        .imem_req_o   (imem_req_o),
        .instr_o      (instr_o),
        .hit_o        (hit_o),
        .busy_o       (busy_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory model: data = address, configurable stalls ----------------
    int          stall_n    = 0;
    bit          noise_en   = 1'b0;
    int          wait_cnt   = 0;
    int          req_cycles = 0;
    logic [31:0] beats[$];
    logic        prev_req   = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_addr  = 32'h0;

    always @(negedge clk) begin
        if (imem_req_o && prev_req && !prev_ready)
            check("imem_addr_stable", imem_addr_o, prev_addr);
        if (imem_req_o) begin
            req_cycles++;
            if (wait_cnt >= stall_n) begin
                imem_ready_i = 1'b1;
                imem_rdata_i = imem_addr_o;
                wait_cnt = 0;
                beats.push_back(imem_addr_o);
            end else begin
                imem_ready_i = 1'b0;
                imem_rdata_i = 32'hDEAD_BEEF;
                wait_cnt++;
            end
        end else begin
            imem_ready_i = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rdata_i = $urandom;
            wait_cnt = 0;
        end
        prev_req   = imem_req_o;
        prev_ready = imem_ready_i;
        prev_addr  = imem_addr_o;
    end

    // ---------------- reference model: which lines are resident ----------------
    bit          m_valid [SETS][WAYS];
    logic [21:0] m_tag   [SETS][WAYS];
    int          m_ptr   [SETS];

    task automatic model_flush();
        for (int s = 0; s < SETS; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endtask

    task automatic model_access(input logic [31:0] a, output bit hit);
        int          s;
        int          v;
        logic [21:0] tg;
        s   = int'((a / (LW * 4)) % SETS);
        tg  = 22'(a / (LW * 4 * SETS));
        hit = 1'b0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == tg) hit = 1'b1;
        if (!hit) begin
            v = -1;
            for (int w = WAYS - 1; w >= 0; w--)
                if (!m_valid[s][w]) v = w;
            if (v < 0) begin
                v = m_ptr[s];
                m_ptr[s] = (m_ptr[s] + 1) % WAYS;
            end
            m_valid[s][v] = 1'b1;
            m_tag[s][v]   = tg;
        end
    endtask

    function automatic int exp_lat(input bit hit);
        return hit ? 1 : 2 + LW * (stall_n + 1);
    endfunction

    // Issue a read at a negedge, hold until hit_o, return cycles taken and instruction
    task automatic read_wait(input logic [31:0] a, output int lat, output logic [31:0] ins);
        read_i = 1'b1;
        addr_i = a;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!hit_o && lat < 300);
        ins = instr_o;
        read_i = 1'b0;
    endtask

    // Count consecutive busy cycles starting at the current negedge
    task automatic count_busy(output int n);
        n = 0;
        while (busy_o && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          exp_hit;
    } vec_t;

    vec_t        vecs [9];
    int          lat;
    int          n;
    int          rc0;
    bit          mh;
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] bv;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Replacement scenario in set 16 after 0x100 is resident in way 0
        vecs[0] = '{32'h0000_0500, 1'b0};
        vecs[1] = '{32'h0000_0900, 1'b0};
        vecs[2] = '{32'h0000_0504, 1'b1};
        vecs[3] = '{32'h0000_0100, 1'b0};
        vecs[4] = '{32'h0000_0908, 1'b1};
        vecs[5] = '{32'h0000_050C, 1'b0};
        vecs[6] = '{32'h0000_0104, 1'b1};
        vecs[7] = '{32'h0000_090C, 1'b0};
        vecs[8] = '{32'h0000_0108, 1'b0};

        model_flush();

        // Reset, then the sweep must last exactly SETS cycles
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("reset_hit", 32'(hit_o), 32'd0);
        check("reset_req", 32'(imem_req_o), 32'd0);
        check("reset_instr", instr_o, 32'h0);
        count_busy(n);
        check("reset_busy_cycles", n, SETS);

        // Cold miss of 0x100 with zero-wait memory
        beats.delete();
        model_access(32'h100, mh);
        read_wait(32'h100, lat, ins);
        check("cold_miss_lat", lat, 6);
        check("cold_miss_instr", ins, 32'h100);
        check("cold_miss_nbeats", beats.size(), 4);
        for (int i = 0; i < 4; i++) begin
            bv = (i < beats.size()) ? beats[i] : 32'hFFFF_FFFF;
            check($sformatf("cold_miss_beat%0d", i), bv, 32'h100 + 32'(4 * i));
        end

        // Back-to-back hits in the same line, no memory traffic
        rc0 = req_cycles;
        model_access(32'h108, mh);
        model_access(32'h10C, mh);
        read_i = 1'b1;
        addr_i = 32'h108;
        @(negedge clk);
        check("b2b_hit0", 32'(hit_o), 32'd1);
        check("b2b_instr0", instr_o, 32'h108);
        addr_i = 32'h10C;
        @(negedge clk);
        check("b2b_hit1", 32'(hit_o), 32'd1);
        check("b2b_instr1", instr_o, 32'h10C);
        read_i = 1'b0;
        @(negedge clk);
        check("b2b_hold_nohit", 32'(hit_o), 32'd0);
        check("b2b_hold_instr", instr_o, 32'h10C);
        check("b2b_no_req", req_cycles - rc0, 0);

        // Table: replacement behaviour in set 16
        for (int i = 0; i < 9; i++) begin
            model_access(vecs[i].addr, mh);
            read_wait(vecs[i].addr, lat, ins);
            check($sformatf("vec%0d_lat", i), lat, exp_lat(vecs[i].exp_hit));
            check($sformatf("vec%0d_instr", i), ins, vecs[i].addr);
        end

        // Memory stalls of 3 cycles before every beat
        stall_n = 3;
        beats.delete();
        model_access(32'h3048, mh);
        read_wait(32'h3048, lat, ins);
        check("stall_lat", lat, 18);
        check("stall_instr", ins, 32'h3048);
        check("stall_nbeats", beats.size(), 4);
        for (int i = 0; i < 4; i++) begin
            bv = (i < beats.size()) ? beats[i] : 32'hFFFF_FFFF;
            check($sformatf("stall_beat%0d", i), bv, 32'h3040 + 32'(4 * i));
        end
        stall_n = 0;

        // Flush pulsed during beat 2 of a refill of 0x200
        read_i = 1'b1;
        addr_i = 32'h200;
        repeat (4) @(negedge clk);
        check("flush_beat2_addr", imem_addr_o, 32'h208);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_refill_nohit", 32'(hit_o), 32'd0);
        @(negedge clk);
        check("flush_respond_hit", 32'(hit_o), 32'd1);
        check("flush_respond_instr", instr_o, 32'h200);
        read_i = 1'b0;
        @(negedge clk);
        count_busy(n);
        check("flush_busy_cycles", n, SETS);
        model_flush();
        model_access(32'h200, mh);
        read_wait(32'h200, lat, ins);
        check("flush_reread_lat", lat, exp_lat(mh));
        check("flush_reread_instr", ins, 32'h200);

        // Reset after beat 1 of a refill of 0x600
        read_i = 1'b1;
        addr_i = 32'h600;
        repeat (4) @(negedge clk);
        check("rst_mid_req_before", 32'(imem_req_o), 32'd1);
        check("rst_mid_addr_before", imem_addr_o, 32'h608);
        rst_i  = 1'b1;
        read_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        check("rst_mid_req", 32'(imem_req_o), 32'd0);
        check("rst_mid_hit", 32'(hit_o), 32'd0);
        check("rst_mid_instr", instr_o, 32'h0);
        count_busy(n);
        check("rst_mid_busy_cycles", n, SETS);
        model_flush();
        model_access(32'h600, mh);
        read_wait(32'h600, lat, ins);
        check("rst_mid_reread_lat", lat, exp_lat(mh));
        check("rst_mid_reread_instr", ins, 32'h600);
        model_access(32'h100, mh);
        read_wait(32'h100, lat, ins);
        check("rst_mid_old_line_lat", lat, exp_lat(mh));

        // Randomized accesses over a few conflicting sets, random stalls and flushes
        noise_en = 1'b1;
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 24) == 0) begin
                flush_i = 1'b1;
                @(negedge clk);
                flush_i = 1'b0;
                check("rnd_flush_busy", 32'(busy_o), 32'd1);
                count_busy(n);
                check("rnd_flush_busy_cycles", n, SETS);
                model_flush();
            end else begin
                case ($urandom_range(0, 3))
                    0: n = 0;
                    1: n = 1;
                    2: n = 16;
                    default: n = 63;
                endcase
                a = (32'($urandom_range(0, 3)) << 10) | (32'(n) << 4) |
                    (32'($urandom_range(0, 3)) << 2);
                stall_n = $urandom_range(0, 2);
                model_access(a, mh);
                read_wait(a, lat, ins);
                check($sformatf("rnd%0d_lat", it), lat, exp_lat(mh));
                check($sformatf("rnd%0d_instr", it), ins, a);
                if ($urandom_range(0, 1) == 1) @(negedge clk);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
